crop_max_buffer: RTL and testbench

Upstream neighbour of the normalization stage. Captures one raster-order 8-bit frame from the camera stream and keeps only an OUT_ROWS×OUT_COLS crop window in an internal buffer. While capturing, it tracks the window's maximum pixel. Once the frame ends, it presents that maximum as `norm_denominator` and replays the cropped pixels on an AXI-Stream master, so the normalizer has a valid coefficient before its first pixel arrives.

---
 rtl/crop_max_buffer.sv | 194 +++++++++++++++++++
 tb/tb_crop_max_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_max_buffer.sv
// Captures one raster frame, keeps an OUT_ROWS x OUT_COLS crop in a local RAM while
// tracking its maximum, then replays the crop on an AXI-Stream master with that maximum.
module crop_max_buffer #(
    parameter int IN_ROWS  = 16,
    parameter int IN_COLS  = 16,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic [$clog2(IN_ROWS)-1:0]   crop_row0,
    input  logic [$clog2(IN_COLS)-1:0]   crop_col0,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [7:0]                   s_axis_tdata,
    output logic [7:0]                   norm_denominator,
    output logic                         norm_denominator_tvalid,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [7:0]                   m_axis_tdata
);
    localparam int RW = $clog2(IN_ROWS);
    localparam int CW = $clog2(IN_COLS);
    localparam int N  = OUT_ROWS * OUT_COLS;
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q, r0_q;
    logic [CW-1:0]   col_q, c0_q;
    logic [AW-1:0]   wr_addr_q;
    logic [AW:0]     rd_addr_q, out_cnt_q;
    logic [7:0]      max_q, max_d;
    logic [7:0]      denom_q, ram_q;
    logic            ap_ready_q, ap_done_q, s_tready_q, denom_vld_q, m_tvalid_q;
    logic [7:0]      mem [N];

    logic [RW:0]     row_sum_s, r0_end_s;
    logic [CW:0]     col_sum_s, c0_end_s;
    logic [RW-1:0]   r0_lat_s;
    logic [CW-1:0]   c0_lat_s;
    logic            in_win_s, beat_s, wr_en_s, last_in_s;
    logic            out_hs_s, rd_en_s, last_out_s;

    // Offsets are pulled back so the whole window always fits inside the frame
    assign row_sum_s = {1'b0, crop_row0} + (RW+1)'(OUT_ROWS);
    assign col_sum_s = {1'b0, crop_col0} + (CW+1)'(OUT_COLS);
    assign r0_lat_s  = (row_sum_s > (RW+1)'(IN_ROWS)) ? RW'(IN_ROWS - OUT_ROWS) : crop_row0;
    assign c0_lat_s  = (col_sum_s > (CW+1)'(IN_COLS)) ? CW'(IN_COLS - OUT_COLS) : crop_col0;

    assign r0_end_s  = {1'b0, r0_q} + (RW+1)'(OUT_ROWS);
    assign c0_end_s  = {1'b0, c0_q} + (CW+1)'(OUT_COLS);
    assign in_win_s  = (row_q >= r0_q) && ({1'b0, row_q} < r0_end_s) &&
                       (col_q >= c0_q) && ({1'b0, col_q} < c0_end_s);
    assign beat_s    = s_tready_q && s_axis_tvalid;
    assign wr_en_s   = beat_s && in_win_s;
    assign last_in_s = beat_s && (row_q == RW'(IN_ROWS - 1)) && (col_q == CW'(IN_COLS - 1));

    // The RAM read register doubles as the output stage: a read is issued only
    // when that stage is empty or draining, giving 1 beat/cycle without drops.
    assign out_hs_s   = m_tvalid_q && m_axis_tready;
    assign rd_en_s    = (state_q == S_EMIT) && (rd_addr_q < (AW+1)'(N)) &&
                        (!m_tvalid_q || m_axis_tready);
    assign last_out_s = out_hs_s && (out_cnt_q == (AW+1)'(N - 1));

    // Running maximum including the beat being accepted this cycle
    always_comb begin
        max_d = max_q;
        if (wr_en_s && (s_axis_tdata > max_q)) begin
            max_d = s_axis_tdata;
        end else begin
            max_d = max_q;
        end
    end

    // Control FSM with all handshake/status outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ap_ready_q  <= 1'b1;
            ap_done_q   <= 1'b0;
            s_tready_q  <= 1'b0;
            denom_vld_q <= 1'b0;
            denom_q     <= 8'd0;
            m_tvalid_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            r0_q        <= '0;
            c0_q        <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            out_cnt_q   <= '0;
            max_q       <= 8'd0;
        end else begin
            ap_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        r0_q       <= r0_lat_s;
                        c0_q       <= c0_lat_s;
                        row_q      <= '0;
                        col_q      <= '0;
                        wr_addr_q  <= '0;
                        max_q      <= 8'd0;
                        ap_ready_q <= 1'b0;
                        s_tready_q <= 1'b1;
                        state_q    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (beat_s) begin
                        if (col_q == CW'(IN_COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (wr_en_s) begin
                            wr_addr_q <= wr_addr_q + AW'(1);
                        end
                        max_q <= max_d;
                        if (last_in_s) begin
                            s_tready_q  <= 1'b0;
                            denom_vld_q <= 1'b1;
                            denom_q     <= (max_d == 8'd0) ? 8'd1 : max_d;
                            rd_addr_q   <= '0;
                            out_cnt_q   <= '0;
                            state_q     <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (rd_en_s) begin
                        rd_addr_q  <= rd_addr_q + (AW+1)'(1);
                        m_tvalid_q <= 1'b1;
                    end else if (out_hs_s) begin
                        m_tvalid_q <= 1'b0;
                    end
                    if (out_hs_s) begin
                        out_cnt_q <= out_cnt_q + (AW+1)'(1);
                    end
                    if (last_out_s) begin
                        ap_done_q   <= 1'b1;
                        ap_ready_q  <= 1'b1;
                        denom_vld_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    ap_ready_q  <= 1'b1;
                    s_tready_q  <= 1'b0;
                    denom_vld_q <= 1'b0;
                    m_tvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Crop buffer write port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_q] <= s_axis_tdata;
        end
    end

    // Crop buffer registered read port, which also holds m_axis_tdata
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_q <= 8'd0;
        end else if (rd_en_s) begin
            ram_q <= mem[rd_addr_q[AW-1:0]];
        end
    end

    assign ap_ready                = ap_ready_q;
    assign ap_idle                 = ap_ready_q;
    assign ap_done                 = ap_done_q;
    assign s_axis_tready           = s_tready_q;
    assign norm_denominator        = denom_q;
    assign norm_denominator_tvalid = denom_vld_q;
    assign m_axis_tvalid           = m_tvalid_q;
    assign m_axis_tdata            = ram_q;

endmodule

// File: tb/tb_crop_max_buffer.sv
// Directed bench for crop_max_buffer on an 8x8 frame with a 4x4 crop window.
module tb_crop_max_buffer;
    localparam int IR = 8;
    localparam int IC = 8;
    localparam int OR = 4;
    localparam int OC = 4;
    localparam int NB = OR * OC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ap_start = 1'b0;
    logic       ap_ready, ap_idle, ap_done;
    logic [2:0] crop_row0 = 3'd0;
    logic [2:0] crop_col0 = 3'd0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] s_axis_tdata = 8'd0;
    logic [7:0] norm_denominator;
    logic       norm_denominator_tvalid;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [7:0] m_axis_tdata;

    always #5 clk = ~clk;

    crop_max_buffer #(.IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .crop_row0(crop_row0), .crop_col0(crop_col0),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .norm_denominator(norm_denominator), .norm_denominator_tvalid(norm_denominator_tvalid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got[$];
    int nbeats, done_cnt, stall_viol, first_cyc, last_cyc, denom_bad;
    logic done_e1, ready_e1, dvld_e1, mvld_e1;

    // Pixel value at raster position (row, col) is row*8+col
    function automatic logic [7:0] exp_pix(input int r0, input int c0, input int i);
        return 8'((r0 + i / OC) * IC + c0 + i % OC);
    endfunction

    task automatic start_frame(input int r0, input int c0);
        crop_row0 = 3'(r0);
        crop_col0 = 3'(c0);
        ap_start  = 1'b1;
        @(negedge clk);
        ap_start  = 1'b0;
    endtask

    task automatic feed_frame(input bit zero, input int busy_start);
        for (int i = 0; i < IR * IC; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = zero ? 8'd0 : 8'(i);
            ap_start      = (i == busy_start);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        ap_start      = 1'b0;
    endtask

    // Drains the output stream, recording beats and protocol observations
    task automatic collect(input bit bp, input int exp_den, input int busy_start);
        bit         prev_stall;
        logic [7:0] prev_data;
        got.delete();
        nbeats = 0; done_cnt = 0; stall_viol = 0; denom_bad = 0;
        first_cyc = -1; last_cyc = -1;
        prev_stall = 1'b0; prev_data = 8'd0;
        for (int c = 0; c < 600 && nbeats < NB; c++) begin
            if (m_axis_tvalid === 1'b1 &&
                (norm_denominator_tvalid !== 1'b1 || norm_denominator !== 8'(exp_den)))
                denom_bad++;
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data))
                stall_viol++;
            if (ap_done === 1'b1) done_cnt++;
            ap_start = (c == busy_start);
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                got.push_back(m_axis_tdata);
                if (nbeats == 0) first_cyc = c;
                last_cyc = c;
                nbeats++;
            end
            prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
            prev_data  = m_axis_tdata;
            @(negedge clk);
        end
        ap_start = 1'b0;
        done_e1  = ap_done;
        ready_e1 = ap_ready;
        dvld_e1  = norm_denominator_tvalid;
        mvld_e1  = m_axis_tvalid;
        if (ap_done === 1'b1) done_cnt++;
        repeat (4) begin
            @(negedge clk);
            if (ap_done === 1'b1) done_cnt++;
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({ap_ready, ap_idle, ap_done} !== 3'b110) begin n_err++;
            $display("FAIL reset_status: got %b want 110", {ap_ready, ap_idle, ap_done}); end
        n_cmp++; if ({s_axis_tready, m_axis_tvalid, norm_denominator_tvalid} !== 3'b000) begin n_err++;
            $display("FAIL reset_valids: got %b want 000", {s_axis_tready, m_axis_tvalid, norm_denominator_tvalid}); end
        n_cmp++; if (norm_denominator !== 8'd0) begin n_err++;
            $display("FAIL reset_denom: got %0d want 0", norm_denominator); end
        n_cmp++; if (m_axis_tdata !== 8'd0) begin n_err++;
            $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ap_idle, s_axis_tready} !== 2'b10) begin n_err++;
            $display("FAIL idle_after_reset: got %b want 10", {ap_idle, s_axis_tready}); end
    endtask

    task automatic test_base_crop();
        start_frame(2, 3);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++;
            $display("FAIL base_tready_t1: got %b want 1", s_axis_tready); end
        n_cmp++; if (ap_ready !== 1'b0) begin n_err++;
            $display("FAIL base_ready_busy: got %b want 0", ap_ready); end
        feed_frame(1'b0, -1);
        n_cmp++; if ({norm_denominator_tvalid, m_axis_tvalid, s_axis_tready} !== 3'b100) begin n_err++;
            $display("FAIL base_end_t1: got %b want 100", {norm_denominator_tvalid, m_axis_tvalid, s_axis_tready}); end
        n_cmp++; if (norm_denominator !== 8'd46) begin n_err++;
            $display("FAIL base_denom: got %0d want 46", norm_denominator); end
        collect(1'b0, 46, -1);
        n_cmp++; if (nbeats !== NB) begin n_err++;
            $display("FAIL base_count: got %0d want %0d", nbeats, NB); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_pix(2, 3, i)) begin n_err++;
                $display("FAIL base_beat%0d: got %0d want %0d", i, got[i], exp_pix(2, 3, i)); end
        end
        n_cmp++; if (first_cyc !== 1) begin n_err++;
            $display("FAIL base_first_latency: got %0d want 1", first_cyc); end
        n_cmp++; if (last_cyc - first_cyc !== NB - 1) begin n_err++;
            $display("FAIL base_back_to_back: got span %0d want %0d", last_cyc - first_cyc, NB - 1); end
        n_cmp++; if (denom_bad !== 0) begin n_err++;
            $display("FAIL base_denom_hold: got %0d bad cycles want 0", denom_bad); end
        n_cmp++; if ({done_e1, ready_e1, dvld_e1, mvld_e1} !== 4'b1100) begin n_err++;
            $display("FAIL base_end_flags: got %b want 1100", {done_e1, ready_e1, dvld_e1, mvld_e1}); end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL base_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        start_frame(2, 3);
        feed_frame(1'b0, -1);
        collect(1'b1, 46, -1);
        n_cmp++; if (nbeats !== NB) begin n_err++;
            $display("FAIL bp_count: got %0d want %0d", nbeats, NB); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_pix(2, 3, i)) begin n_err++;
                $display("FAIL bp_beat%0d: got %0d want %0d", i, got[i], exp_pix(2, 3, i)); end
        end
        n_cmp++; if (stall_viol !== 0) begin n_err++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
        n_cmp++; if (denom_bad !== 0) begin n_err++;
            $display("FAIL bp_denom_hold: got %0d bad cycles want 0", denom_bad); end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_clamp();
        start_frame(7, 7);
        feed_frame(1'b0, -1);
        n_cmp++; if (norm_denominator !== 8'd63) begin n_err++;
            $display("FAIL clamp_denom: got %0d want 63", norm_denominator); end
        collect(1'b0, 63, -1);
        n_cmp++; if (nbeats !== NB) begin n_err++;
            $display("FAIL clamp_count: got %0d want %0d", nbeats, NB); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_pix(4, 4, i)) begin n_err++;
                $display("FAIL clamp_beat%0d: got %0d want %0d", i, got[i], exp_pix(4, 4, i)); end
        end
    endtask

    task automatic test_zero_frame();
        start_frame(2, 3);
        feed_frame(1'b1, -1);
        n_cmp++; if ({norm_denominator_tvalid, norm_denominator} !== {1'b1, 8'd1}) begin n_err++;
            $display("FAIL zero_denom: got vld %b val %0d want vld 1 val 1", norm_denominator_tvalid, norm_denominator); end
        collect(1'b1, 1, -1);
        n_cmp++; if (nbeats !== NB) begin n_err++;
            $display("FAIL zero_count: got %0d want %0d", nbeats, NB); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== 8'd0) begin n_err++;
                $display("FAIL zero_beat%0d: got %0d want 0", i, got[i]); end
        end
        n_cmp++; if (denom_bad !== 0) begin n_err++;
            $display("FAIL zero_denom_hold: got %0d bad cycles want 0", denom_bad); end
    endtask

    task automatic test_reset_mid_emit();
        int hs;
        start_frame(2, 3);
        feed_frame(1'b0, -1);
        m_axis_tready = 1'b1;
        hs = 0;
        for (int c = 0; c < 100 && hs < 5; c++) begin
            if (m_axis_tvalid === 1'b1) hs++;
            @(negedge clk);
        end
        n_cmp++; if (hs !== 5) begin n_err++;
            $display("FAIL rst_emit_beats: got %0d want 5", hs); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ap_ready, ap_idle, ap_done, s_axis_tready, m_axis_tvalid, norm_denominator_tvalid} !== 6'b110000) begin n_err++;
            $display("FAIL rst_emit_flags: got %b want 110000",
                     {ap_ready, ap_idle, ap_done, s_axis_tready, m_axis_tvalid, norm_denominator_tvalid}); end
        n_cmp++; if ({norm_denominator, m_axis_tdata} !== 16'd0) begin n_err++;
            $display("FAIL rst_emit_data: got denom %0d tdata %0d want 0 0", norm_denominator, m_axis_tdata); end
        reset = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        start_frame(2, 3);
        feed_frame(1'b0, -1);
        collect(1'b0, 46, -1);
        n_cmp++; if (nbeats !== NB) begin n_err++;
            $display("FAIL rst_fresh_count: got %0d want %0d", nbeats, NB); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_pix(2, 3, i)) begin n_err++;
                $display("FAIL rst_fresh_beat%0d: got %0d want %0d", i, got[i], exp_pix(2, 3, i)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL rst_fresh_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        start_frame(2, 3);
        crop_row0 = 3'd0;
        crop_col0 = 3'd0;
        feed_frame(1'b0, 20);
        collect(1'b0, 46, 5);
        n_cmp++; if (nbeats !== NB) begin n_err++;
            $display("FAIL busy_count: got %0d want %0d", nbeats, NB); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_pix(2, 3, i)) begin n_err++;
                $display("FAIL busy_beat%0d: got %0d want %0d", i, got[i], exp_pix(2, 3, i)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if ({ap_idle, s_axis_tready} !== 2'b10) begin n_err++;
            $display("FAIL busy_no_restart: got %b want 10", {ap_idle, s_axis_tready}); end
    endtask

    initial begin
        test_reset();
        test_base_crop();
        test_backpressure();
        test_clamp();
        test_zero_frame();
        test_reset_mid_emit();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
